// File: rtl/llapi_pkg.sv
// Shared types and constants for the LLAPI -> N64 pad adapter.
// The optional right-stick C-button feature is selected with LLAPI_N64_CSTICK_EN.
package llapi_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_CAPTURE = 2'd1;
    localparam state_t ST_CONV    = 2'd2;
    localparam state_t ST_PUBLISH = 2'd3;

    // Bit positions inside PAD_BUTTONS
    typedef enum logic [3:0] {
        BTN_CR    = 4'd0,
        BTN_CL    = 4'd1,
        BTN_CD    = 4'd2,
        BTN_CU    = 4'd3,
        BTN_R     = 4'd4,
        BTN_L     = 4'd5,
        BTN_RSV0  = 4'd6,
        BTN_RSV1  = 4'd7,
        BTN_RIGHT = 4'd8,
        BTN_LEFT  = 4'd9,
        BTN_DOWN  = 4'd10,
        BTN_UP    = 4'd11,
        BTN_START = 4'd12,
        BTN_Z     = 4'd13,
        BTN_B     = 4'd14,
        BTN_A     = 4'd15
    } n64_btn_e;

    localparam int AXIS_CENTER      = 32'sd128;
    localparam int N64_AXIS_MAX     = 32'sd80;
    localparam int AXIS_SCALE_NUM   = 32'sd5;
    localparam int AXIS_SCALE_SHIFT = 32'sd3;

endpackage

// File: rtl/llapi_axis_conv.sv
// One stick axis: recentre, optional negate, deadzone, scale by 5/8, clamp to +/-80.
module llapi_axis_conv
    import llapi_pkg::*;
#(
    parameter int DEADZONE = 8
) (
    input  logic        [7:0] axis,
    input  logic              invert,
    output logic signed [7:0] value
);

    localparam logic signed [9:0]  DZ_POS  = 10'(DEADZONE);
    localparam logic signed [9:0]  DZ_NEG  = -DZ_POS;
    localparam logic signed [12:0] MAX_POS = 13'(N64_AXIS_MAX);
    localparam logic signed [12:0] MAX_NEG = -MAX_POS;
    localparam logic signed [12:0] SCALE   = 13'(AXIS_SCALE_NUM);

    logic signed [9:0]  off_s;
    logic signed [9:0]  s_s;
    logic signed [12:0] prod_s;
    logic signed [12:0] shr_s;

    // Ten bits keep the negated -128 as +128, so a fully-up stick reaches +80
    always_comb begin
        off_s  = $signed({2'b00, axis}) - $signed(10'(AXIS_CENTER));
        if (invert) begin
            s_s = -off_s;
        end else begin
            s_s = off_s;
        end
        prod_s = $signed({{3{s_s[9]}}, s_s}) * SCALE;
        shr_s  = prod_s >>> AXIS_SCALE_SHIFT;
        if ((s_s <= DZ_POS) && (s_s >= DZ_NEG)) begin
            value = 8'sd0;
        end else if (shr_s > MAX_POS) begin
            value = MAX_POS[7:0];
        end else if (shr_s < MAX_NEG) begin
            value = MAX_NEG[7:0];
        end else begin
            value = shr_s[7:0];
        end
    end

endmodule

// File: rtl/llapi_n64_pad.sv
// LLAPI pad state -> N64 controller state, published once per frame-poll edge.
// Define LLAPI_N64_CSTICK_EN to drive the C-buttons from the right analog stick.
module llapi_n64_pad
    import llapi_pkg::*;
#(
    parameter int DEADZONE = 8,
    parameter int CTHRESH  = 64
) (
    input  logic        CLK_50M,
    input  logic        RESET,
    input  logic        LLAPI_SYNC,
    input  logic        LLAPI_EN,
    input  logic [31:0] LLAPI_BUTTONS,
    input  logic [71:0] LLAPI_ANALOG,
    output logic [15:0] PAD_BUTTONS,
    output logic [7:0]  PAD_X,
    output logic [7:0]  PAD_Y,
    output logic        PAD_VALID,
    output logic        PAD_UPDATE,
    output logic [7:0]  SYNC_DROPS
);

    logic        sync_meta_q, sync_q, sync_prev_q;
    logic [2:0]  arm_q;
    logic        edge_s;

    state_t      state_q, state_d;

    logic        snap_en_q;
    logic [31:0] snap_btn_q;
    logic [7:0]  snap_x1_q, snap_y1_q;

    logic signed [7:0] x_s, y_s;
    logic [15:0] map_s;

    logic [15:0] btn_q, btn_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic        valid_q, valid_d;
    logic        upd_q, upd_d;
    logic [7:0]  drops_q, drops_d;

    logic        unused_s;

    // Synchroniser plus arming chain: an edge only counts once sync_prev_q holds real post-reset input
    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
            arm_q       <= 3'b000;
        end else begin
            sync_meta_q <= LLAPI_SYNC;
            sync_q      <= sync_meta_q;
            sync_prev_q <= sync_q;
            arm_q       <= {arm_q[1:0], 1'b1};
        end
    end

    assign edge_s = arm_q[2] & sync_q & ~sync_prev_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (edge_s) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: state_d = ST_CONV;
            ST_CONV:    state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Input snapshot taken during CAPTURE
    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            snap_en_q  <= 1'b0;
            snap_btn_q <= 32'h0;
            snap_x1_q  <= 8'h00;
            snap_y1_q  <= 8'h00;
        end else if (state_q == ST_CAPTURE) begin
            snap_en_q  <= LLAPI_EN;
            snap_btn_q <= LLAPI_BUTTONS;
            snap_x1_q  <= LLAPI_ANALOG[7:0];
            snap_y1_q  <= LLAPI_ANALOG[15:8];
        end else begin
            snap_en_q  <= snap_en_q;
            snap_btn_q <= snap_btn_q;
            snap_x1_q  <= snap_x1_q;
            snap_y1_q  <= snap_y1_q;
        end
    end

    llapi_axis_conv #(.DEADZONE(DEADZONE)) u_conv_x (
        .axis   (snap_x1_q),
        .invert (1'b0),
        .value  (x_s)
    );

    llapi_axis_conv #(.DEADZONE(DEADZONE)) u_conv_y (
        .axis   (snap_y1_q),
        .invert (1'b1),
        .value  (y_s)
    );

`ifdef LLAPI_N64_CSTICK_EN
    localparam logic [7:0] C_LO = 8'(AXIS_CENTER - CTHRESH);
    localparam logic [7:0] C_HI = 8'(AXIS_CENTER + CTHRESH);

    logic [7:0] snap_x2_q, snap_y2_q;

    // Right-stick snapshot, captured alongside the main snapshot
    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            snap_x2_q <= 8'h00;
            snap_y2_q <= 8'h00;
        end else if (state_q == ST_CAPTURE) begin
            snap_x2_q <= LLAPI_ANALOG[31:24];
            snap_y2_q <= LLAPI_ANALOG[39:32];
        end else begin
            snap_x2_q <= snap_x2_q;
            snap_y2_q <= snap_y2_q;
        end
    end
`endif

    // Button mapping from the snapshot
    always_comb begin
        map_s            = 16'h0000;
        map_s[BTN_A]     = snap_btn_q[1];
        map_s[BTN_B]     = snap_btn_q[0];
        map_s[BTN_Z]     = snap_btn_q[8];
        map_s[BTN_START] = snap_btn_q[5];
        map_s[BTN_UP]    = snap_btn_q[27];
        map_s[BTN_DOWN]  = snap_btn_q[26];
        map_s[BTN_LEFT]  = snap_btn_q[25];
        map_s[BTN_RIGHT] = snap_btn_q[24];
        map_s[BTN_L]     = snap_btn_q[6];
        map_s[BTN_R]     = snap_btn_q[7];
`ifdef LLAPI_N64_CSTICK_EN
        map_s[BTN_CU]    = (snap_y2_q < C_LO);
        map_s[BTN_CD]    = (snap_y2_q > C_HI);
        map_s[BTN_CL]    = (snap_x2_q < C_LO);
        map_s[BTN_CR]    = (snap_x2_q > C_HI);
`else
        map_s[BTN_CU]    = snap_btn_q[2];
        map_s[BTN_CD]    = snap_btn_q[3];
        map_s[BTN_CL]    = snap_btn_q[14];
        map_s[BTN_CR]    = snap_btn_q[15];
`endif
    end

    // Output next-state: results land on the CONV->PUBLISH edge so PUBLISH shows them with the pulse
    always_comb begin
        btn_d   = btn_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;
        upd_d   = 1'b0;
        drops_d = drops_q;
        if (state_q == ST_CONV) begin
            upd_d = 1'b1;
            if (snap_en_q) begin
                btn_d   = map_s;
                x_d     = x_s;
                y_d     = y_s;
                valid_d = 1'b1;
            end else begin
                btn_d   = 16'h0000;
                x_d     = 8'h00;
                y_d     = 8'h00;
                valid_d = 1'b0;
            end
        end else begin
            upd_d = 1'b0;
        end
        if (edge_s && (state_q != ST_IDLE) && (drops_q != 8'hFF)) begin
            drops_d = drops_q + 8'd1;
        end else begin
            drops_d = drops_q;
        end
    end

    // Published output registers
    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            btn_q   <= 16'h0000;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
            drops_q <= 8'h00;
        end else begin
            btn_q   <= btn_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            drops_q <= drops_d;
        end
    end

    assign PAD_BUTTONS = btn_q;
    assign PAD_X       = x_q;
    assign PAD_Y       = y_q;
    assign PAD_VALID   = valid_q;
    assign PAD_UPDATE  = upd_q;
    assign SYNC_DROPS  = drops_q;

    // Button bits and analog lanes that have no N64 meaning are folded here
    assign unused_s = ^{LLAPI_ANALOG, snap_btn_q};

endmodule
